// File: rtl/proc_pkg.sv
// Shared definitions for the parametrised multicycle processor: opcodes,
// step encoding and a constant-evaluable ceil(log2) helper.
package proc_pkg;

    localparam logic [3:0] OP_MV   = 4'd0;
    localparam logic [3:0] OP_MVI  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_MVNZ = 4'd10;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/proc_alu.sv
// Combinational ALU: arithmetic, logic, signed compare and logical shifts.
// carry is the add carry-out or the subtract borrow, zero for everything else.
module proc_alu
    import proc_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    localparam int SH_W = clog2(DATA_W);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    // The extra top bit of a widened subtraction is exactly the unsigned borrow.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: {carry, result} = sum;
            OP_SUB: {carry, result} = diff;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL: result = a << b[SH_W-1:0];
            OP_SRL: result = a >> b[SH_W-1:0];
            default: ;
        endcase
    end

endmodule

// File: rtl/proc_multiciclo_param.sv
// Multicycle processor top: step FSM, register file, A/G registers, flags
// and the one-hot internal bus feeding the ALU and register writes.
module proc_multiciclo_param
    import proc_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int NREGS  = 8,
    localparam int RSEL_W = clog2(NREGS),
    localparam int IR_W   = 4 + 2 * RSEL_W
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              run,
    input  logic [DATA_W-1:0] din,
    output logic              done,
    output logic              busy,
    output logic [DATA_W-1:0] bus_out,
    output logic              zero,
    output logic              negative,
    output logic              carry,
    input  logic [RSEL_W-1:0] dbg_sel,
    output logic [DATA_W-1:0] dbg_reg
);

    step_t             step_reg, step_next;
    logic [IR_W-1:0]   ir_reg;
    logic [DATA_W-1:0] a_reg, g_reg;
    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] bus, alu_result;
    logic              alu_carry;

    logic [3:0]        op;
    logic [RSEL_W-1:0] rx, ry;
    logic              is_alu;
    logic              ir_load, a_load, g_load, reg_we;
    logic              sel_ry, sel_din, sel_g;

    assign op     = ir_reg[IR_W-1 -: 4];
    assign rx     = ir_reg[2*RSEL_W-1:RSEL_W];
    assign ry     = ir_reg[RSEL_W-1:0];
    assign is_alu = (op >= OP_ADD) && (op <= OP_SRL);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) step_reg <= T0;
        else         step_reg <= step_next;
    end

    always_comb begin
        step_next = T0;
        case (step_reg)
            T0: step_next = run ? T1 : T0;
            T1: step_next = is_alu ? T2 : T0;
            T2: step_next = T3;
            T3: step_next = T0;
            default: step_next = T0;
        endcase
    end

    always_comb begin
        done    = 1'b0;
        busy    = (step_reg != T0);
        ir_load = 1'b0;
        a_load  = 1'b0;
        g_load  = 1'b0;
        reg_we  = 1'b0;
        sel_ry  = 1'b0;
        sel_din = 1'b0;
        sel_g   = 1'b0;
        case (step_reg)
            T0: ir_load = run;
            T1: begin
                if (is_alu) begin
                    a_load = 1'b1;
                end else begin
                    done = 1'b1;
                    case (op)
                        OP_MV:   begin sel_ry  = 1'b1; reg_we = 1'b1;  end
                        OP_MVI:  begin sel_din = 1'b1; reg_we = 1'b1;  end
                        OP_MVNZ: begin sel_ry  = 1'b1; reg_we = !zero; end
                        default: ;
                    endcase
                end
            end
            T2: begin sel_ry = 1'b1; g_load = 1'b1; end
            T3: begin sel_g = 1'b1; reg_we = 1'b1; done = 1'b1; end
            default: ;
        endcase
    end

    assign bus = ({DATA_W{sel_ry}}  & regs[ry])
               | ({DATA_W{sel_din}} & din)
               | ({DATA_W{sel_g}}   & g_reg);
    assign bus_out = bus;

    // In T2 the bus carries Ry, so it doubles as the ALU's second operand.
    proc_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (op),
        .a      (a_reg),
        .b      (bus),
        .result (alu_result),
        .carry  (alu_carry)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ir_reg   <= '0;
            a_reg    <= '0;
            g_reg    <= '0;
            zero     <= 1'b1;
            negative <= 1'b0;
            carry    <= 1'b0;
        end else begin
            if (ir_load) ir_reg <= din[IR_W-1:0];
            if (a_load)  a_reg  <= regs[rx];
            if (g_load) begin
                g_reg    <= alu_result;
                zero     <= (alu_result == '0);
                negative <= alu_result[DATA_W-1];
                carry    <= alu_carry;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (reg_we) begin
            regs[rx] <= bus;
        end
    end

    assign dbg_reg = regs[dbg_sel];

endmodule

// File: tb/tb_proc_multiciclo_param.sv
// Directed bench: an instruction-level model predicts done/busy/bus/flags/registers
// each cycle; literal checks after key instructions pin the model's results.
module tb_proc_multiciclo_param;

    localparam int DW = 16;
    localparam int NR = 8;
    localparam int RS = 3;

    localparam logic [3:0] MV = 4'd0, MVI = 4'd1, ADD = 4'd2, SUB = 4'd3, AND_ = 4'd4,
                           OR_ = 4'd5, XOR_ = 4'd6, SLT = 4'd7, SLL = 4'd8, SRL = 4'd9,
                           MVNZ = 4'd10, NOP12 = 4'd12;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          run = 1'b0;
    logic [DW-1:0] din = '0;
    logic          done, busy, zero, negative, carry;
    logic [DW-1:0] bus_out, dbg_reg;
    logic [RS-1:0] dbg_sel = '0;

    always #5 clock = ~clock;

    proc_multiciclo_param #(.DATA_W(DW), .NREGS(NR)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .run      (run),
        .din      (din),
        .done     (done),
        .busy     (busy),
        .bus_out  (bus_out),
        .zero     (zero),
        .negative (negative),
        .carry    (carry),
        .dbg_sel  (dbg_sel),
        .dbg_reg  (dbg_reg)
    );

    // Model state, plus writes pending until the next cycle boundary.
    logic [DW-1:0] m_reg [NR];
    logic          m_zero, m_neg, m_carry;
    logic          e_done, e_busy;
    logic [DW-1:0] e_bus;
    logic          p_we, p_fl, p_c;
    logic [2:0]    p_rx;
    logic [DW-1:0] p_val, p_res;

    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    bit  chk_en = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clock) begin
        #1;
        if (chk_en) begin
            chk("done",     done,     e_done);
            chk("busy",     busy,     e_busy);
            chk("bus_out",  bus_out,  e_bus);
            chk("zero",     zero,     m_zero);
            chk("negative", negative, m_neg);
            chk("carry",    carry,    m_carry);
            chk("dbg_reg",  dbg_reg,  m_reg[dbg_sel]);
        end
    end

    function automatic logic [DW:0] m_alu(input logic [3:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
        int unsigned ua, ub, sh, s;
        logic [DW-1:0] r;
        logic c;
        ua = a; ub = b; sh = ub % DW; c = 1'b0; r = '0;
        case (op)
            ADD:  begin s = ua + ub; r = DW'(s); c = (s > 32'h0000FFFF); end
            SUB:  begin r = DW'(ua - ub); c = (ua < ub); end
            AND_: r = a & b;
            OR_:  r = a | b;
            XOR_: r = a ^ b;
            SLT:  r = ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
            SLL:  r = DW'(ua << sh);
            SRL:  r = DW'(ua >> sh);
            default: ;
        endcase
        return {c, r};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_reg[i] = '0;
        m_zero = 1'b1; m_neg = 1'b0; m_carry = 1'b0;
        p_we = 1'b0; p_fl = 1'b0;
        e_done = 1'b0; e_busy = 1'b0; e_bus = '0;
    endtask

    task automatic next_cycle();
        @(negedge clock);
        if (p_we) m_reg[p_rx] = p_val;
        if (p_fl) begin
            m_zero = (p_res == '0); m_neg = p_res[DW-1]; m_carry = p_c;
        end
        p_we = 1'b0; p_fl = 1'b0;
        cyc++;
        dbg_sel = RS'(cyc % NR);
        e_done = 1'b0; e_busy = 1'b0; e_bus = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            next_cycle();
            run = 1'b0;
            din = DW'($urandom);
        end
    endtask

    task automatic do_instr(input logic [3:0] op, input logic [2:0] rx, input logic [2:0] ry,
                            input logic [DW-1:0] imm, input bit drop_run);
        logic          alu;
        logic [DW-1:0] a_val;
        logic [DW:0]   r;
        alu = (op >= ADD) && (op <= SRL);
        next_cycle();
        din = {6'b0, op, rx, ry};
        run = 1'b1;
        next_cycle();
        run = drop_run ? 1'b0 : 1'b1;
        din = (op == MVI) ? imm : DW'($urandom);
        e_busy = 1'b1;
        a_val = m_reg[rx];
        if (!alu) begin
            e_done = 1'b1;
            case (op)
                MV:   begin e_bus = m_reg[ry]; p_we = 1'b1; p_rx = rx; p_val = m_reg[ry]; end
                MVI:  begin e_bus = imm; p_we = 1'b1; p_rx = rx; p_val = imm; end
                MVNZ: begin e_bus = m_reg[ry]; p_we = !m_zero; p_rx = rx; p_val = m_reg[ry]; end
                default: ;
            endcase
        end else begin
            next_cycle();
            din = DW'($urandom);
            e_busy = 1'b1;
            e_bus = m_reg[ry];
            r = m_alu(op, a_val, m_reg[ry]);
            p_fl = 1'b1; p_res = r[DW-1:0]; p_c = r[DW];
            next_cycle();
            din = DW'($urandom);
            e_busy = 1'b1; e_done = 1'b1;
            e_bus = r[DW-1:0];
            p_we = 1'b1; p_rx = rx; p_val = r[DW-1:0];
        end
    endtask

    task automatic pin_reg(input string name, input int sel, input logic [DW-1:0] exp);
        next_cycle();
        run = 1'b0;
        din = '0;
        dbg_sel = RS'(sel);
        #2;
        chk(name, dbg_reg, exp);
    endtask

    task automatic pin_flags(input string name, input logic z, input logic n, input logic c);
        #2;
        chk({name, "_zero"}, zero, z);
        chk({name, "_neg"}, negative, n);
        chk({name, "_carry"}, carry, c);
    endtask

    initial begin
        model_reset();
        resetn = 1'b0;
        chk_en = 1'b1;
        idle(3);
        next_cycle();
        resetn = 1'b1;
        idle(5);
        pin_flags("reset", 1'b1, 1'b0, 1'b0);

        do_instr(MVI, 3'd0, 3'd0, 16'h0005, 1'b0);  pin_reg("mvi_r0", 0, 16'h0005);
        do_instr(MVI, 3'd1, 3'd0, 16'h0003, 1'b0);  pin_reg("mvi_r1", 1, 16'h0003);
        do_instr(ADD, 3'd0, 3'd1, '0, 1'b0);        pin_reg("add_r0", 0, 16'h0008);
        pin_flags("add", 1'b0, 1'b0, 1'b0);
        do_instr(SUB, 3'd1, 3'd0, '0, 1'b0);        pin_reg("sub_r1", 1, 16'hFFFB);
        pin_flags("sub", 1'b0, 1'b1, 1'b1);

        do_instr(MVI, 3'd2, 3'd0, 16'h00F0, 1'b0);
        do_instr(MVI, 3'd3, 3'd0, 16'h0004, 1'b0);
        do_instr(SLL, 3'd2, 3'd3, '0, 1'b0);        pin_reg("sll_r2", 2, 16'h0F00);
        do_instr(SLT, 3'd3, 3'd2, '0, 1'b0);        pin_reg("slt_r3", 3, 16'h0001);
        do_instr(XOR_, 3'd2, 3'd2, '0, 1'b0);       pin_reg("xor_r2", 2, 16'h0000);
        pin_flags("xor", 1'b1, 1'b0, 1'b0);

        do_instr(MVI, 3'd4, 3'd0, 16'h1234, 1'b0);
        do_instr(MVNZ, 3'd4, 3'd2, '0, 1'b0);       pin_reg("mvnz_hold", 4, 16'h1234);
        do_instr(ADD, 3'd3, 3'd3, '0, 1'b0);        pin_reg("add_dbl_r3", 3, 16'h0002);
        do_instr(MVNZ, 3'd4, 3'd2, '0, 1'b0);       pin_reg("mvnz_copy", 4, 16'h0000);

        do_instr(MVI, 3'd6, 3'd0, 16'hFFFF, 1'b0);
        do_instr(ADD, 3'd6, 3'd1, '0, 1'b0);        pin_reg("add_ovf_r6", 6, 16'hFFFA);
        pin_flags("add_ovf", 1'b0, 1'b1, 1'b1);
        do_instr(SRL, 3'd6, 3'd3, '0, 1'b1);        pin_reg("srl_r6", 6, 16'h3FFE);
        pin_flags("srl", 1'b0, 1'b0, 1'b0);
        do_instr(AND_, 3'd6, 3'd1, '0, 1'b0);       pin_reg("and_r6", 6, 16'h3FFA);
        do_instr(OR_, 3'd0, 3'd2, '0, 1'b0);        pin_reg("or_r0", 0, 16'h0008);
        do_instr(MV, 3'd7, 3'd6, '0, 1'b0);         pin_reg("mv_r7", 7, 16'h3FFA);
        do_instr(NOP12, 3'd7, 3'd0, '0, 1'b0);      pin_reg("nop_r7", 7, 16'h3FFA);
        do_instr(MV, 3'd0, 3'd0, '0, 1'b0);         pin_reg("mv_self", 0, 16'h0008);
        do_instr(MVI, 3'd5, 3'd0, 16'h0007, 1'b0);

        // add R5,R5 aborted by reset during T2
        next_cycle();
        din = {6'b0, ADD, 3'd5, 3'd5};
        run = 1'b1;
        next_cycle();
        e_busy = 1'b1;
        din = DW'($urandom);
        next_cycle();
        resetn = 1'b0;
        run = 1'b0;
        model_reset();
        idle(2);
        next_cycle();
        resetn = 1'b1;
        idle(2);
        pin_reg("abort_r5", 5, 16'h0000);
        pin_flags("abort", 1'b1, 1'b0, 1'b0);

        do_instr(MVI, 3'd5, 3'd0, 16'hA5A5, 1'b0);  pin_reg("post_reset_r5", 5, 16'hA5A5);
        idle(2);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/proc_multiciclo_param.md
Name: proc_multiciclo_param

Overview:
Parametrised multicycle processor, the next generation of the pratica2 datapath. Fetches instructions and immediates from din under the run/done handshake. Adds a register file of configurable width and depth, a wider opcode field, logic, shift and compare operations, conditional move, status flags and a debug read port. Sits at the top of the lab design and is driven by a bench or instruction source.

Parameters:
DATA_W, 16, datapath, register, bus and din width (min 8, power of 2)
NREGS, 8, number of general registers (power of 2, 2..16); RSEL_W = clog2(NREGS)
IR_W, 4+2*RSEL_W (derived localparam, 10 by default), instruction width = {op[3:0], rx, ry}

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
run  in  1  start request; sampled only in T0
din  in  DATA_W  instruction (low IR_W bits) in T0; immediate in T1 of mvi
done  out  1  high during the final step cycle of each instruction
busy  out  1  high in T1..T3
bus_out  out  DATA_W  current internal bus value
zero  out  1  G == 0 flag
negative  out  1  G[DATA_W-1] flag
carry  out  1  carry/borrow flag
dbg_sel  in  RSEL_W  register select for debug read
dbg_reg  out  DATA_W  R[dbg_sel], combinational

Behaviour:
- Reset (async, resetn=0): step=T0; IR, A, G, all R[i] = 0; zero=1, negative=0, carry=0. done=0, busy=0, bus_out=0. A reset mid-instruction aborts it and causes no write.
- FSM steps T0..T3. T0: if run=1, IR <= din[IR_W-1:0] and go to T1; otherwise stay in T0 (idle, bus=0).
- Opcodes (4 bit):
  - 0 mv: T1: Rx <= Ry, done.
  - 1 mvi: T1: Rx <= din, done.
  - 2 add, 3 sub, 4 and, 5 or, 6 xor, 7 slt, 8 sll, 9 srl:
    - T1: A <= Rx.
    - T2: G <= A op Ry; flags update.
    - T3: Rx <= G, done.
  - 10 mvnz: T1: if zero=0 then Rx <= Ry; done is asserted either way.
  - 11..15 reserved: NOP, done in T1, no state change.
- After the done cycle, return to T0. Instruction latency: 2 cycles for mv/mvi/mvnz/NOP, 4 cycles for ALU ops, counting the T0 fetch.
- done is combinational from step and IR, high for exactly one cycle. run is ignored while busy.
- Arithmetic:
  - add: carry = unsigned carry out.
  - sub: carry = borrow (1 iff A < Ry unsigned); results wrap mod 2^DATA_W.
  - slt: G = 1 if A < Ry signed, else 0.
  - sll/srl: shift amount = Ry[clog2(DATA_W)-1:0], logical. carry=0 for all logic, shift and compare ops.
  - zero and negative are taken from the new G value.
- Flags change only in T2 of ALU ops.
- Bus source per step (one-hot mux): Ry, din, or G, else 0. bus_out mirrors the bus.
- rx == ry is legal. For example, add R2,R2 doubles R2, and mv Rx,Rx is a no-op write.
- dbg_reg reflects register writes in the cycle after the write edge.

Decomposition:
- Package proc_pkg:
  - opcode localparams (OP_MV..OP_MVNZ)
  - step encoding T0..T3
  - function clog2
- One sub-module, proc_alu: combinational op/A/B in, result plus carry out, parametrised by DATA_W.
- Register file, FSM and bus mux stay in the top.

Test Plan:
- Reset/idle: hold resetn=0 then release with run=0 for 5 cycles -> all R=0, zero=1, done=0 throughout, busy=0.
- mvi: din=10'h040 (mvi R0), next cycle din=16'h0005 -> done in cycle 2, dbg_reg(R0)=5. Repeat with din=10'h048/16'h0003 -> R1=3.
- add/sub: add R0,R1 (10'h081) -> done on 4th cycle, R0=8, carry=0. sub R1,R0 (10'h0C8) -> R1=16'hFFFB, carry=1, negative=1.
- Logic/shift/slt: R2=16'h00F0, R3=4. sll R2,R3 -> 16'h0F00. slt R3,R2 -> R3=1. xor R2,R2 -> 0 and zero=1.
- mvnz: after xor gives zero=1, mvnz R4,R2 -> R4 unchanged. After add gives nonzero, the same instruction copies. done is asserted both times.
- Reset mid-op: assert resetn=0 during T2 of add R5,R5 -> immediate T0, R5=0, no done pulse. Also drop run during T1 -> the instruction still completes.
